// File: rtl/delay_15_pkg.sv
// delay_15_pkg: shared types and constants for the delay_15 line and its controller.
package delay_15_pkg;
    localparam int DELAY_W = 4;
    localparam int FLUSH_DEFAULT = 16;
    typedef logic [DELAY_W-1:0] delay_t;
    typedef enum logic {ST_FLUSH, ST_RUN} ctrl_state_t;
endpackage

// File: rtl/delay_15.sv
// delay_15: serial delay line with a runtime-selectable tap of 0..15 cycles.
module delay_15
    import delay_15_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   data_i,
    input  delay_t data_delay_i,
    output logic   data_o
);
    logic [14:0] shreg_q;
    logic [15:0] tap;
    // tap[k] is data_i from k cycles ago; tap[0] is the live input
    assign tap = {shreg_q, data_i};
    assign data_o = tap[data_delay_i];
    always_ff @(posedge clk_i) begin
        if (rst_i) shreg_q <= '0;
        else       shreg_q <= {shreg_q[13:0], data_i};
    end
endmodule

// File: rtl/delay_15_ctrl.sv
// delay_15_ctrl: applies handshaked delay changes to delay_15 and blanks the
// output qualifier for a fixed flush window after each change or reset.
module delay_15_ctrl #(
    parameter int DELAY_W      = delay_15_pkg::DELAY_W,
    parameter int FLUSH_CYCLES = delay_15_pkg::FLUSH_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DELAY_W-1:0] cfg_delay_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic               data_i,
    output logic               data_o,
    output logic               data_valid_o,
    output logic [DELAY_W-1:0] delay_o,
    output logic               busy_o
);
    import delay_15_pkg::*;
    localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);
    ctrl_state_t        state_q, state_d;
    logic [7:0]         flush_cnt_q, flush_cnt_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               change;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= FLUSH_INIT;
            delay_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            delay_q     <= delay_d;
        end
    end
    // Same-value requests are consumed without restarting the flush
    always_comb begin
        change      = cfg_valid_i && state_q == ST_RUN && cfg_delay_i != delay_q;
        delay_d     = change ? cfg_delay_i : delay_q;
        flush_cnt_d = change ? FLUSH_INIT
                    : (state_q == ST_FLUSH && flush_cnt_q != 8'd0) ? flush_cnt_q - 8'd1
                    : flush_cnt_q;
        state_d     = change ? ST_FLUSH
                    : (state_q == ST_FLUSH && flush_cnt_q == 8'd0) ? ST_RUN
                    : state_q;
    end
    always_comb begin
        cfg_ready_o  = state_q == ST_RUN;
        data_valid_o = state_q == ST_RUN;
        busy_o       = state_q == ST_FLUSH;
        delay_o      = delay_q;
    end
    delay_15 u_delay (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .data_delay_i (delay_t'(delay_q)),
        .data_o       (data_o)
    );
endmodule

// File: tb/tb_delay_15_ctrl.sv
// tb_delay_15_ctrl: directed checks of reset, delay change, handshake and flush
// timing, plus a randomized soak against a reference delay-line history.
module tb_delay_15_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cfg_delay;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       data_in;
    logic       data_out;
    logic       data_valid;
    logic [3:0] delay_out;
    logic       busy;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [14:0] past;
    logic        m_run;
    logic [7:0]  m_cnt;
    logic [3:0]  m_delay;

    always #5 clk = ~clk;

    delay_15_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_delay_i  (cfg_delay),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .data_i       (data_in),
        .data_o       (data_out),
        .data_valid_o (data_valid),
        .delay_o      (delay_out),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the reference model at the edge, drive new data,
    // then compare every output against the model at the falling edge.
    task automatic tick();
        logic exp_d;
        @(posedge clk);
        if (rst) begin
            past = '0; m_run = 1'b0; m_cnt = 8'd15; m_delay = 4'd0;
        end else begin
            past = {past[13:0], data_in};
            if (m_run && cfg_valid && cfg_delay != m_delay) begin
                m_delay = cfg_delay; m_cnt = 8'd15; m_run = 1'b0;
            end else if (!m_run) begin
                if (m_cnt == 8'd0) m_run = 1'b1;
                else m_cnt = m_cnt - 8'd1;
            end
        end
        #1 data_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("m_delay", 32'(delay_out), 32'(m_delay));
        chk("m_valid", 32'(data_valid), 32'(m_run));
        chk("m_ready", 32'(cfg_ready), 32'(m_run));
        chk("m_busy", 32'(busy), 32'(!m_run));
        if (m_run) begin
            exp_d = (m_delay == 4'd0) ? data_in : past[m_delay - 4'd1];
            chk("m_data", 32'(data_out), 32'(exp_d));
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_delay = 4'd0; data_in = 1'b0;
        past = '0; m_run = 1'b0; m_cnt = 8'd15; m_delay = 4'd0;
        // reset release
        tick(); tick();
        chk("rst_delay", 32'(delay_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("rel_valid_low", 32'(data_valid), 32'd0);
            tick();
        end
        chk("rel_valid_high", 32'(data_valid), 32'd1);
        chk("rel_ready_high", 32'(cfg_ready), 32'd1);
        chk("rel_busy_low", 32'(busy), 32'd0);
        // delay change to 5
        cfg_delay = 4'd5; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("chg_delay", 32'(delay_out), 32'd5);
        for (int i = 0; i < 16; i++) begin
            chk("chg_valid_low", 32'(data_valid), 32'd0);
            tick();
        end
        chk("chg_valid_high", 32'(data_valid), 32'd1);
        for (int i = 0; i < 30; i++) tick();
        // same-value request keeps RUN
        cfg_delay = 4'd5; cfg_valid = 1'b1;
        chk("same_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        chk("same_valid", 32'(data_valid), 32'd1);
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_delay", 32'(delay_out), 32'd5);
        tick();
        chk("same_valid2", 32'(data_valid), 32'd1);
        // request held during a flush
        cfg_delay = 4'd7; cfg_valid = 1'b1;
        tick();
        cfg_delay = 4'd9;
        for (int i = 0; i < 16; i++) begin
            chk("hold_ready_low", 32'(cfg_ready), 32'd0);
            tick();
        end
        chk("hold_ready_high", 32'(cfg_ready), 32'd1);
        chk("hold_delay7", 32'(delay_out), 32'd7);
        tick();
        cfg_valid = 1'b0;
        chk("hold_delay9", 32'(delay_out), 32'd9);
        for (int i = 0; i < 16; i++) begin
            chk("hold_valid_low", 32'(data_valid), 32'd0);
            tick();
        end
        chk("hold_valid_high", 32'(data_valid), 32'd1);
        // reset mid-flush
        cfg_delay = 4'd12; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("mid_delay12", 32'(delay_out), 32'd12);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_delay", 32'(delay_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("mid_valid_low", 32'(data_valid), 32'd0);
            tick();
        end
        chk("mid_valid_high", 32'(data_valid), 32'd1);
        chk("mid_delay0", 32'(delay_out), 32'd0);
        // random soak; a pending request is held until the model says it was taken
        for (int i = 0; i < 1000; i++) begin
            if (!cfg_valid || m_run) begin
                cfg_valid = ($urandom_range(0, 4) == 0);
                cfg_delay = 4'($urandom_range(0, 15));
            end
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/delay_15_ctrl.md
# delay_15_ctrl

Sequencing controller wrapped around the `delay_15` variable delay line. It accepts delay-change requests over a valid/ready handshake and applies each new delay to the line. It then blanks the output qualifier for a fixed flush window, so downstream logic never consumes samples produced while the line contents are inconsistent with the new tap. It sits between the configuration source and the `delay_15` instance and owns that instance's `data_delay_i` input.

## Interface
- `DELAY_W`, default 4: width of the delay value; fixed by `delay_15`.
- `FLUSH_CYCLES`, default 16: length of the flush window after any delay change or reset, in clock cycles; legal range is 1..255.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `cfg_delay_i` in DELAY_W: requested delay, 0..15 cycles.
- `cfg_valid_i` in 1: the delay request is valid.
- `cfg_ready_o` out 1: the controller can accept a request.
- `data_i` in 1: serial data into the delay line.
- `data_o` out 1: delay line output, passed through unregistered.
- `data_valid_o` out 1: `data_o` reflects `data_i` delayed by `delay_o`.
- `delay_o` out DELAY_W: the delay currently applied to the line.
- `busy_o` out 1: a flush is in progress.

## Operation
- The controller has two states, FLUSH and RUN.
- A 8-bit down-counter `flush_cnt` times the flush window.
- FLUSH:
  - `cfg_ready_o`=0, `data_valid_o`=0, `busy_o`=1.
  - `flush_cnt` decrements once per cycle.
  - When `flush_cnt`==0, the state moves to RUN on the next edge.
- RUN:
  - `cfg_ready_o`=1, `data_valid_o`=1, `busy_o`=0.
- Handshake: a request transfers on a cycle where `cfg_valid_i` && `cfg_ready_o` are both high at the rising edge. Requests are never queued.
- The requester must hold `cfg_delay_i` stable while `cfg_valid_i`=1 and `cfg_ready_o`=0.
- Accepted request with `cfg_delay_i` != `delay_o`:
  - `delay_o` <= `cfg_delay_i`.
  - `flush_cnt` <= FLUSH_CYCLES-1.
  - State <= FLUSH.
- Accepted request with `cfg_delay_i` == `delay_o`: the request is consumed, the state stays RUN, and `data_valid_o` does not drop.
- `delay_o` drives `delay_15.data_delay_i` directly. `data_i` and `data_o` are connected straight through; the controller never gates data.
- Reset:
  - `delay_o`=0, state=FLUSH, `flush_cnt`=FLUSH_CYCLES-1.
  - `cfg_ready_o`=0, `data_valid_o`=0, `busy_o`=1.
  - The delay line reset follows `rst_i`.
- Reset asserted mid-flush or mid-handshake aborts the operation. Any request in flight is lost and the sequence restarts from the reset values.
- The request value is a 4-bit unsigned number with no range check; all codes 0..15 are legal.

## Timing
- Request accepted at edge N with a changed delay:
  - `delay_o` takes the new value after edge N.
  - `data_valid_o` and `cfg_ready_o` are low from edge N through edge N+FLUSH_CYCLES-1.
  - Both go high after edge N+FLUSH_CYCLES.
  - The flush window is exactly FLUSH_CYCLES cycles.
- After `rst_i` deasserts at edge R, `data_valid_o` rises after edge R+FLUSH_CYCLES.
- The next request can be accepted on the first cycle with `cfg_ready_o`=1. Back-to-back changes are therefore spaced FLUSH_CYCLES+1 edges apart.
- `data_o` has the latency of `delay_15`: `data_o`(t) = `data_i`(t-`delay_o`). With a delay of 0, `data_o` is combinational from `data_i`.
- `cfg_ready_o`, `data_valid_o` and `busy_o` are decoded combinationally from the state register only; there is no input-to-output combinational path.
- With FLUSH_CYCLES=1, the state returns to RUN one cycle after acceptance.

## Structure
- Package `delay_15_pkg`:
  - `DELAY_W`=4.
  - `delay_t` = logic [DELAY_W-1:0].
  - State enum `ctrl_state_t` {ST_FLUSH, ST_RUN}.
  - Default flush length constant `FLUSH_DEFAULT`=16.
- One sub-module: the `delay_15` instance, `u_delay`. All controller logic stays in `delay_15_ctrl`.

## Test plan
- Reset release: hold `rst_i`=1 for 2 cycles, then drop it. `delay_o`=0, `data_valid_o`=0 for 16 cycles, then 1, with `cfg_ready_o` following the same profile.
- Delay change: in RUN, request delay 5 for one cycle. `delay_o`=5 on the next cycle and `data_valid_o` is low for exactly 16 cycles. Afterwards, random `data_i` checks `data_o`(t) == `data_i`(t-5) on every valid cycle.
- Same-value request: in RUN with `delay_o`=5, request 5. The request is accepted in one cycle and `data_valid_o` stays 1 throughout.
- Request during flush: assert `cfg_valid_i` with value 9 while busy. `cfg_ready_o`=0 holds the request until flush end. It is accepted on the first RUN cycle, followed by a second 16-cycle flush; `delay_o`=9.
- Reset mid-flush: request delay 12 and assert `rst_i` 7 cycles into the flush. `delay_o` returns to 0 and a full 16-cycle flush restarts after release.
- Random soak: 1000 cycles of random `data_i`, with a random delay request (0..15) issued with probability 1/5. A scoreboard history checks `data_o` on every `data_valid_o`=1 cycle; zero mismatches are required.
